program_sequencer: RTL

- Fetch/sequence controller for the instruction RAM. It owns the program counter, drives the RAM read address, and decodes the control-flow opcodes: Nop, Jump, Pre Branch, Branch on Zero, Jump to register, and Hlt.
- Gates instruction issue to the datapath and reports halt/fault status.
- Sits between the instruction RAM (combinational read) and the CPU datapath.

---
 rtl/program_sequencer_pkg.sv | 35 +++
 rtl/program_sequencer_if.sv | 35 +++
 rtl/program_sequencer_next_pc_logic.sv | 62 ++++++
 rtl/program_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared ISA definitions for the fetch sequencer:
// opcodes, sequencer states and default widths.
package program_sequencer_pkg;

    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int COUNT_WIDTH_DEF = 32;

    // Control-flow opcodes decoded by the sequencer
    localparam logic [5:0] OP_NOP   = 6'b011011;
    localparam logic [5:0] OP_JMP   = 6'b010101;
    localparam logic [5:0] OP_BZ    = 6'b010011;
    localparam logic [5:0] OP_PREBR = 6'b011111;
    localparam logic [5:0] OP_HLT   = 6'b011100;
    localparam logic [5:0] OP_JR    = 6'b100011;

    // Datapath opcodes; the sequencer only advances past these
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_LD    = 6'b100000;
    localparam logic [5:0] OP_ST    = 6'b101000;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_RUN   = 2'd1;
    localparam seq_state_t ST_HALT  = 2'd2;
    localparam seq_state_t ST_FAULT = 2'd3;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Bus between the sequencer, the instruction RAM and the datapath.
// slave = sequencer side, master = RAM/datapath side.
interface program_sequencer_if
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);

    logic                   start;
    logic                   stall;
    logic [31:0]            instruction;
    logic [31:0]            branchValue;
    logic [31:0]            jumpRegValue;
    logic [ADDR_WIDTH-1:0]  address;
    logic                   instrValid;
    logic                   halted;
    logic                   fault;
    logic [COUNT_WIDTH-1:0] retiredCount;

    modport slave (
        input  start, stall, instruction,
        input  branchValue, jumpRegValue,
        output address, instrValid, halted,
        output fault, retiredCount
    );

    modport master (
        output start, stall, instruction,
        output branchValue, jumpRegValue,
        input  address, instrValid, halted,
        input  fault, retiredCount
    );

endinterface

// File: rtl/program_sequencer_next_pc_logic.sv
// Combinational next-PC / zero-flag computation with bounds check.
// Target is computed one bit wider so pc+1 past the top cannot wrap.
module program_sequencer_next_pc_logic
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int PROGRAM_DEPTH = 1024
) (
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [5:0]            opcode_i,
    input  logic [ADDR_WIDTH-1:0] imm_i,
    input  logic                  zero_flag_i,
    input  logic [31:0]           branch_value_i,
    input  logic [31:0]           jump_reg_value_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  next_zero_flag_o,
    output logic                  is_halt_o,
    output logic                  out_of_range_o
);

    localparam logic [ADDR_WIDTH:0] ONE_W   = 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = PROGRAM_DEPTH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] pc_inc;
    logic [ADDR_WIDTH:0] target;
    logic                is_jmp;
    logic                is_bz;
    logic                is_prebr;
    logic                is_jr;
    logic                is_hlt;
    logic                unused_jr_hi;

    assign unused_jr_hi = ^jump_reg_value_i[31:ADDR_WIDTH];

    assign pc_inc   = {1'b0, pc_i} + ONE_W;
    assign is_jmp   = (opcode_i == OP_JMP);
    assign is_bz    = (opcode_i == OP_BZ);
    assign is_prebr = (opcode_i == OP_PREBR);
    assign is_jr    = (opcode_i == OP_JR);
    assign is_hlt   = (opcode_i == OP_HLT);

    always_comb begin
        target           = pc_inc;
        next_zero_flag_o = zero_flag_i;
        is_halt_o        = 1'b0;
        unique case (1'b1)
            is_jmp:   target = {1'b0, imm_i};
            is_bz:    target = zero_flag_i ? {1'b0, imm_i} : pc_inc;
            is_prebr: next_zero_flag_o = (branch_value_i == 32'd0);
            is_jr:    target = {1'b0, jump_reg_value_i[ADDR_WIDTH-1:0]};
            is_hlt: begin
                target    = {1'b0, pc_i};
                is_halt_o = 1'b1;
            end
            default:  target = pc_inc;
        endcase
    end

    assign next_pc_o      = target[ADDR_WIDTH-1:0];
    assign out_of_range_o = (target >= DEPTH_W);

endmodule

// File: rtl/program_sequencer.sv
// Instruction fetch sequencer: owns the PC, gates issue to the datapath
// and tracks halt/fault status plus a saturating retired count.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int PROGRAM_DEPTH = 1024,
    parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
) (
    input logic               clock,
    input logic               reset,
    program_sequencer_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

    seq_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   zf_q, zf_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                  issue;
    logic [ADDR_WIDTH-1:0] nxt_pc;
    logic                  nxt_zf;
    logic                  nxt_halt;
    logic                  nxt_oor;
    logic                  unused_instr;

    assign unused_instr = ^bus.instruction[25:ADDR_WIDTH];

    program_sequencer_next_pc_logic #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .PROGRAM_DEPTH (PROGRAM_DEPTH)
    ) u_next_pc (
        .pc_i             (pc_q),
        .opcode_i         (opcode_of(bus.instruction)),
        .imm_i            (bus.instruction[ADDR_WIDTH-1:0]),
        .zero_flag_i      (zf_q),
        .branch_value_i   (bus.branchValue),
        .jump_reg_value_i (bus.jumpRegValue),
        .next_pc_o        (nxt_pc),
        .next_zero_flag_o (nxt_zf),
        .is_halt_o        (nxt_halt),
        .out_of_range_o   (nxt_oor)
    );

    assign issue = (state_q == ST_RUN) && !bus.stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        zf_d    = zf_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            (state_q == ST_RUN): begin
                if (issue) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
                    zf_d  = nxt_zf;
                    if (nxt_halt) begin
                        state_d = ST_HALT;
                    end else if (nxt_oor) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = nxt_pc;
                    end
                end
            end
            // start restarts from address 0 regardless of stall
            default: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    zf_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            zf_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            zf_q    <= zf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.address      = pc_q;
    assign bus.instrValid   = issue;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.fault        = (state_q == ST_FAULT);
    assign bus.retiredCount = cnt_q;

endmodule
